// File: rtl/k_dp_sync_fifo_if.sv
// Producer/consumer handshake and status bundle for k_dp_sync_fifo.
// master = the side that pushes/pops, slave = the FIFO itself.
interface k_dp_sync_fifo_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 2
);
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              underflow;

    modport master (
        output wr_en, wr_data, rd_en,
        input  rd_data, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en,
        output rd_data, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/k_dp_sync_fifo.sv
// Single-clock show-ahead FIFO over a 2^ADDR_W x DATA_W register array with
// wrap-bit pointers, occupancy flags and one-cycle overflow/underflow pulses.
module k_dp_sync_fifo #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ADDR_W    = 2,
    parameter int unsigned AFULL_TH  = (1 << ADDR_W) - 1,
    parameter int unsigned AEMPTY_TH = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    k_dp_sync_fifo_if.slave        bus
);
    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned PTR_W = ADDR_W + 1;
    localparam logic [PTR_W-1:0] AFULL_C  = PTR_W'(AFULL_TH);
    localparam logic [PTR_W-1:0] AEMPTY_C = PTR_W'(AEMPTY_TH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic [PTR_W-1:0]  count_s;
    logic              empty_s;
    logic              full_s;
    logic              push_ok_s;
    logic              pop_ok_s;

    // Status is a pure decode of the registered pointers; requests never feed it.
    assign count_s   = wr_ptr_q - rd_ptr_q;
    assign empty_s   = (wr_ptr_q == rd_ptr_q);
    assign full_s    = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                       (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);
    assign push_ok_s = bus.wr_en && (!full_s || bus.rd_en);
    assign pop_ok_s  = bus.rd_en && !empty_s;

    assign bus.count        = count_s;
    assign bus.empty        = empty_s;
    assign bus.full         = full_s;
    assign bus.almost_full  = (count_s >= AFULL_C);
    assign bus.almost_empty = (count_s <= AEMPTY_C);
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
    assign bus.rd_data      = empty_s ? {DATA_W{1'b0}} : mem_q[rd_ptr_q[ADDR_W-1:0]];

    // Next-state for pointers and error pulses.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        overflow_d  = bus.wr_en && full_s && !bus.rd_en;
        underflow_d = bus.rd_en && empty_s;
    end

    // Pointer and error-pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= {PTR_W{1'b0}};
            rd_ptr_q    <= {PTR_W{1'b0}};
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array; left unreset since empty masks stale contents.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q[ADDR_W-1:0]] <= bus.wr_data;
        end
    end
endmodule

// File: tb/tb_k_dp_sync_fifo.sv
// Scoreboard bench for k_dp_sync_fifo: directed scenarios plus randomized
// push/pop traffic checked against a queue-based reference model.
module tb_k_dp_sync_fifo;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 2;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int AFULL  = DEPTH - 1;
    localparam int AEMPTY = 1;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    k_dp_sync_fifo_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    k_dp_sync_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of stored bytes plus pending error pulses.
    logic [DATA_W-1:0] mdl_q [$];
    bit exp_ovf;
    bit exp_udf;

    initial begin
        exp_ovf = 1'b0;
        exp_udf = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mdl_q.delete();
                exp_ovf = 1'b0;
                exp_udf = 1'b0;
                chk("rst_count", int'(bus.count), 0);
                chk("rst_empty", int'(bus.empty), 1);
                chk("rst_full", int'(bus.full), 0);
                chk("rst_rd_data", int'(bus.rd_data), 0);
                chk("rst_aempty", int'(bus.almost_empty), 1);
                chk("rst_afull", int'(bus.almost_full), 0);
                chk("rst_ovf", int'(bus.overflow), 0);
                chk("rst_udf", int'(bus.underflow), 0);
            end else begin
                int sz;
                bit push_acc;
                sz = mdl_q.size();
                chk("count", int'(bus.count), sz);
                chk("empty", int'(bus.empty), int'(sz == 0));
                chk("full", int'(bus.full), int'(sz == DEPTH));
                chk("almost_full", int'(bus.almost_full), int'(sz >= AFULL));
                chk("almost_empty", int'(bus.almost_empty), int'(sz <= AEMPTY));
                chk("overflow", int'(bus.overflow), int'(exp_ovf));
                chk("underflow", int'(bus.underflow), int'(exp_udf));
                if (sz == 0) begin
                    chk("rd_data_empty", int'(bus.rd_data), 0);
                end else if (bus.rd_en) begin
                    chk("pop_data", int'(bus.rd_data), int'(mdl_q.pop_front()));
                end else begin
                    chk("head_data", int'(bus.rd_data), int'(mdl_q[0]));
                end
                push_acc = bus.wr_en && ((sz < DEPTH) || bus.rd_en);
                if (push_acc) mdl_q.push_back(bus.wr_data);
                exp_ovf = bus.wr_en && (sz == DEPTH) && !bus.rd_en;
                exp_udf = bus.rd_en && (sz == 0);
            end
        end
    end

    // Inputs change 1 time unit after the rising edge and hold for a full cycle.
    task automatic drive(input bit w, input bit r, input logic [DATA_W-1:0] d);
        bus.wr_en   = w;
        bus.rd_en   = r;
        bus.wr_data = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [DATA_W-1:0] fill_pat [4];
        logic [DATA_W-1:0] seq;
        tests = 0;
        fails = 0;
        fill_pat[0] = 8'h11; fill_pat[1] = 8'h22; fill_pat[2] = 8'h33; fill_pat[3] = 8'h44;
        rst_n       = 1'b0;
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.wr_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 8'h00);

        // Fill then drain.
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, fill_pat[i]);
        chk("fill_full", int'(bus.full), 1);
        chk("fill_count", int'(bus.count), 4);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 8'h00);
        chk("drain_empty", int'(bus.empty), 1);

        // Overflow while full, then drain to confirm order is intact.
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, fill_pat[i]);
        drive(1'b1, 1'b0, 8'h55);
        chk("ovf_pulse", int'(bus.overflow), 1);
        chk("ovf_count", int'(bus.count), 4);
        chk("ovf_head", int'(bus.rd_data), 8'h11);
        drive(1'b0, 1'b0, 8'h00);
        chk("ovf_one_cycle", int'(bus.overflow), 0);

        // Full with simultaneous push and pop.
        chk("both_full_head", int'(bus.rd_data), 8'h11);
        drive(1'b1, 1'b1, 8'h99);
        chk("both_full_count", int'(bus.count), 4);
        chk("both_full_no_ovf", int'(bus.overflow), 0);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 8'h00);
        chk("both_full_drained", int'(bus.empty), 1);

        // Underflow with concurrent push into an empty FIFO.
        drive(1'b1, 1'b1, 8'hA5);
        chk("udf_pulse", int'(bus.underflow), 1);
        chk("udf_count", int'(bus.count), 1);
        chk("udf_data", int'(bus.rd_data), 8'hA5);
        drive(1'b0, 1'b1, 8'h00);

        // Randomized traffic in several push/pop bias regimes.
        for (int ph = 0; ph < 4; ph++) begin
            int pw;
            int pr;
            pw = (ph == 0) ? 80 : (ph == 1) ? 30 : (ph == 2) ? 50 : 90;
            pr = (ph == 0) ? 30 : (ph == 1) ? 80 : (ph == 2) ? 50 : 90;
            for (int c = 0; c < 150; c++) begin
                drive(($urandom_range(0, 99) < pw), ($urandom_range(0, 99) < pr),
                      DATA_W'($urandom()));
            end
        end
        for (int i = 0; i < DEPTH; i++) drive(1'b0, 1'b1, 8'h00);

        // Streaming across the pointer wrap, then asynchronous reset mid-stream.
        seq = 8'h01;
        drive(1'b1, 1'b0, seq); seq++;
        drive(1'b1, 1'b0, seq); seq++;
        for (int c = 0; c < 20; c++) begin
            drive(1'b1, 1'b1, seq);
            seq++;
        end
        chk("stream_count", int'(bus.count), 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_count", int'(bus.count), 0);
        chk("async_empty", int'(bus.empty), 1);
        chk("async_full", int'(bus.full), 0);
        chk("async_rd_data", int'(bus.rd_data), 0);
        chk("async_aempty", int'(bus.almost_empty), 1);
        chk("async_afull", int'(bus.almost_full), 0);
        chk("async_ovf", int'(bus.overflow), 0);
        chk("async_udf", int'(bus.underflow), 0);
        @(posedge clk);
        #1;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 8'h3C);
        chk("post_rst_data", int'(bus.rd_data), 8'h3C);
        drive(1'b0, 1'b1, 8'h00);
        drive(1'b0, 1'b0, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
